// File: rtl/rx_ber_pkg.sv
// rtl/rx_ber_pkg.sv - PRBS9 constants, sync-state encoding and saturating add for the BER checker
package rx_ber_pkg;

   localparam int PRBS_ORDER = 9;
   localparam int PRBS_TAP_A = 9;
   localparam int PRBS_TAP_B = 5;
   localparam int SAT_W      = 64;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } sync_state_e;

   // Counters of any width up to SAT_W are zero-extended into this helper
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [1:0]       inc,
                                                input logic [SAT_W-1:0] max_v);
      logic [SAT_W:0] sum;
      sum = {1'b0, a} + {{(SAT_W-1){1'b0}}, inc};
      return (sum > {1'b0, max_v}) ? max_v : sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/prbs9_sync_checker.sv
// rtl/prbs9_sync_checker.sv - self-synchronising PRBS9 checker for one hard-decision branch
module prbs9_sync_checker
   import rx_ber_pkg::*;
#(
   parameter int LOCK_CNT = 64,
   parameter int WIN_LEN  = 1024,
   parameter int LOSS_THR = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic d_valid,
   output logic locked,
   output logic mismatch
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WIN_LEN);
   localparam int EW = $clog2(WIN_LEN + 1);

   sync_state_e           state_q, state_d;
   logic [PRBS_ORDER-1:0] sr_q, sr_d;
   logic [MW-1:0]         match_q, match_d;
   logic [WW-1:0]         win_q, win_d;
   logic [EW-1:0]         errw_q, errw_d, errw_tot;
   logic                  p;

   assign p        = sr_q[PRBS_TAP_A-1] ^ sr_q[PRBS_TAP_B-1];
   assign locked   = (state_q == ST_LOCKED);
   assign mismatch = locked & d_valid & (p != d);
   assign errw_tot = errw_q + EW'(p != d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SEARCH;
         sr_q    <= '0;
         match_q <= '0;
         win_q   <= '0;
         errw_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         match_q <= match_d;
         win_q   <= win_d;
         errw_q  <= errw_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      match_d = match_q;
      win_d   = win_q;
      errw_d  = errw_q;
      if (d_valid) begin
         if (state_q == ST_SEARCH) begin
            sr_d = {sr_q[PRBS_ORDER-2:0], d};
            // An all-zero register predicts zeros forever, so it must never count towards lock
            if ((p == d) && (sr_q != '0)) begin
               if (match_q == MW'(LOCK_CNT - 1)) begin
                  state_d = ST_LOCKED;
                  match_d = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end else begin
               match_d = '0;
            end
         end else begin
            sr_d = {sr_q[PRBS_ORDER-2:0], p};
            if (win_q == WW'(WIN_LEN - 1)) begin
               win_d  = '0;
               errw_d = '0;
               if (errw_tot >= EW'(LOSS_THR)) begin
                  state_d = ST_SEARCH;
                  match_d = '0;
               end
            end else begin
               win_d  = win_q + 1'b1;
               errw_d = errw_tot;
            end
         end
      end
   end

endmodule

// File: rtl/rx_prbs_ber_checker.sv
// rtl/rx_prbs_ber_checker.sv - QPSK slicer, dual PRBS9 sync checkers and saturating BER counters
// Optional RX_ERR_INJECT_EN adds err_inject, which inverts the I decision of the current symbol.
module rx_prbs_ber_checker
   import rx_ber_pkg::*;
#(
   parameter int DWIDTH   = 16,
   parameter int LOCK_CNT = 64,
   parameter int WIN_LEN  = 1024,
   parameter int LOSS_THR = 64,
   parameter int CNT_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic signed [DWIDTH-1:0] In_I,
   input  logic signed [DWIDTH-1:0] In_Q,
`ifdef RX_ERR_INJECT_EN
   input  logic                     err_inject,
`endif
   output logic                     lock,
   output logic [CNT_W-1:0]         bit_count,
   output logic [CNT_W-1:0]         err_count,
   output logic                     err_I,
   output logic                     err_Q
);

   localparam logic [SAT_W-1:0]         CNT_MAX = {{(SAT_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
   localparam logic signed [DWIDTH-1:0] ZERO    = '0;

   logic             inj;
   logic             dv_q, di_q, dq_q;
   logic             lock_i, lock_q, mis_i, mis_q, count_en;
   logic [CNT_W-1:0] bit_q, bit_d, ecnt_q, ecnt_d;
   logic             pi_q, pq_q;

`ifdef RX_ERR_INJECT_EN
   assign inj = in_valid & err_inject;
`else
   assign inj = 1'b0;
`endif

   // Hard decision is the sign: negative slices to 1, zero and positive to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_q <= 1'b0;
         di_q <= 1'b0;
         dq_q <= 1'b0;
      end else begin
         dv_q <= in_valid;
         if (in_valid) begin
            di_q <= (In_I < ZERO) ^ inj;
            dq_q <= (In_Q < ZERO);
         end
      end
   end

   prbs9_sync_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) u_chk_i (
      .clk(clk), .rst(rst), .d(di_q), .d_valid(dv_q), .locked(lock_i), .mismatch(mis_i)
   );

   prbs9_sync_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) u_chk_q (
      .clk(clk), .rst(rst), .d(dq_q), .d_valid(dv_q), .locked(lock_q), .mismatch(mis_q)
   );

   assign lock     = lock_i & lock_q;
   assign count_en = dv_q & lock;

   always_comb begin
      bit_d  = bit_q;
      ecnt_d = ecnt_q;
      if (clr) begin
         bit_d  = '0;
         ecnt_d = '0;
      end else if (count_en) begin
         bit_d  = CNT_W'(sat_add({{(SAT_W-CNT_W){1'b0}}, bit_q}, 2'd2, CNT_MAX));
         ecnt_d = CNT_W'(sat_add({{(SAT_W-CNT_W){1'b0}}, ecnt_q},
                                 {1'b0, mis_i} + {1'b0, mis_q}, CNT_MAX));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_q  <= '0;
         ecnt_q <= '0;
         pi_q   <= 1'b0;
         pq_q   <= 1'b0;
      end else begin
         bit_q  <= bit_d;
         ecnt_q <= ecnt_d;
         pi_q   <= count_en & mis_i;
         pq_q   <= count_en & mis_q;
      end
   end

   assign bit_count = bit_q;
   assign err_count = ecnt_q;
   assign err_I     = pi_q;
   assign err_Q     = pq_q;

endmodule

// File: tb/tb_rx_prbs_ber_checker.sv
// tb/tb_rx_prbs_ber_checker.sv - randomized self-checking bench for rx_prbs_ber_checker
module tb_rx_prbs_ber_checker;

   localparam int  CW       = 12;
   localparam int  LOCK_CNT = 64;
   localparam int  WIN_LEN  = 1024;
   localparam int  LOSS_THR = 64;
   localparam longint CMAX  = (64'd1 << CW) - 1;
`ifdef RX_ERR_INJECT_EN
   localparam bit INJ_EN = 1'b1;
`else
   localparam bit INJ_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               clr = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] In_I = '0;
   logic signed [15:0] In_Q = '0;
   logic               lock, err_I, err_Q;
   logic [CW-1:0]      bit_count, err_count;
`ifdef RX_ERR_INJECT_EN
   logic               err_inject = 1'b0;
`endif

   always #5 clk = ~clk;

   rx_prbs_ber_checker #(.DWIDTH(16), .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN),
                         .LOSS_THR(LOSS_THR), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .In_I(In_I), .In_Q(In_Q),
`ifdef RX_ERR_INJECT_EN
      .err_inject(err_inject),
`endif
      .lock(lock), .bit_count(bit_count), .err_count(err_count), .err_I(err_I), .err_Q(err_Q)
   );

   int checks = 0;
   int failures = 0;
   int pulses_i = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
      end
   endtask

   // Transmitter: one PRBS9 generator per branch
   logic [8:0] tx_s[2];

   task automatic tx_bit(input int b, output bit o);
      o = tx_s[b][8] ^ tx_s[b][4];
      tx_s[b] = {tx_s[b][7:0], o};
   endtask

   // Reference model: bit history per branch, prediction b[n] = b[n-9] ^ b[n-5]
   bit     m_hist[2][0:32767];
   int     m_n[2], m_run[2], m_wpos[2], m_werr[2];
   bit     m_lk[2];
   bit     s1_v;
   bit     s1_d[2];
   longint e_bit, e_err;
   bit     e_lk, e_ei, e_eq;

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 9; k++) m_hist[b][k] = 1'b0;
         m_n[b] = 9; m_run[b] = 0; m_wpos[b] = 0; m_werr[b] = 0; m_lk[b] = 1'b0;
         s1_d[b] = 1'b0;
      end
      s1_v = 1'b0; e_bit = 0; e_err = 0; e_lk = 1'b0; e_ei = 1'b0; e_eq = 1'b0;
   endtask

   task automatic model_edge(input bit v, input bit di, input bit dq, input bit c);
      bit both, pred, nz, dd;
      bit mis[2];
      int n;
      both = m_lk[0] & m_lk[1];
      mis[0] = 1'b0; mis[1] = 1'b0;
      if (s1_v) begin
         for (int b = 0; b < 2; b++) begin
            dd = s1_d[b]; n = m_n[b];
            pred = m_hist[b][n-9] ^ m_hist[b][n-5];
            nz = 1'b0;
            for (int k = 1; k <= 9; k++) nz |= m_hist[b][n-k];
            if (!m_lk[b]) begin
               m_hist[b][n] = dd;
               if (pred == dd && nz) begin
                  m_run[b]++;
                  if (m_run[b] == LOCK_CNT) begin
                     m_lk[b] = 1'b1; m_run[b] = 0; m_wpos[b] = 0; m_werr[b] = 0;
                  end
               end else begin
                  m_run[b] = 0;
               end
            end else begin
               m_hist[b][n] = pred;
               mis[b] = (pred != dd);
               m_werr[b] += int'(mis[b]);
               m_wpos[b]++;
               if (m_wpos[b] == WIN_LEN) begin
                  if (m_werr[b] >= LOSS_THR) begin
                     m_lk[b] = 1'b0; m_run[b] = 0;
                  end
                  m_wpos[b] = 0; m_werr[b] = 0;
               end
            end
            m_n[b] = n + 1;
         end
      end
      e_ei = s1_v & both & mis[0];
      e_eq = s1_v & both & mis[1];
      if (c) begin
         e_bit = 0; e_err = 0;
      end else if (s1_v && both) begin
         e_bit = (e_bit + 2 > CMAX) ? CMAX : e_bit + 2;
         e_err = (e_err + mis[0] + mis[1] > CMAX) ? CMAX : e_err + mis[0] + mis[1];
      end
      e_lk = m_lk[0] & m_lk[1];
      s1_v = v;
      if (v) begin
         s1_d[0] = di; s1_d[1] = dq;
      end
   endtask

   task automatic cyc(input bit v, input logic signed [15:0] si, input logic signed [15:0] sq,
                      input bit c, input bit inj);
      @(negedge clk);
      chk("lock", lock, e_lk);
      chk("bit_count", bit_count, e_bit);
      chk("err_count", err_count, e_err);
      chk("err_I", err_I, e_ei);
      chk("err_Q", err_Q, e_eq);
      if (err_I) pulses_i++;
      in_valid = v; In_I = si; In_Q = sq; clr = c;
`ifdef RX_ERR_INJECT_EN
      err_inject = inj;
`endif
      model_edge(v, (si < 0) ^ (INJ_EN & inj & v), (sq < 0), c);
   endtask

   // mode: 0 PRBS, 1 all-zero data, 2 random bits; amp 0 selects a random amplitude
   task automatic sym(input bit v, input int mode, input int amp, input bit inj,
                      input bit flipq, input bit c);
      bit b[2];
      logic signed [15:0] s[2];
      logic signed [15:0] a;
      for (int k = 0; k < 2; k++) begin
         if (!v || mode == 1) b[k] = 1'b0;
         else if (mode == 0) tx_bit(k, b[k]);
         else b[k] = 1'($urandom_range(0, 1));
         a = 16'(amp);
         if (amp == 0) begin
            a = 16'($urandom_range(1, 127));
            if (!b[k] && $urandom_range(0, 9) == 0) a = '0;
         end
         s[k] = b[k] ? -a : a;
      end
      if (!INJ_EN && inj) s[0] = -s[0];
      if (flipq) s[1] = -s[1];
      cyc(v, s[0], s[1], c, inj);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
      #1;
      chk("rst_lock", lock, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_I", err_I, 0);
      chk("rst_err_Q", err_Q, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_lock(input int maxn, output int n);
      n = 0;
      while (!lock && n < maxn) begin
         sym(1, 0, 90, 0, 0, 0);
         n++;
      end
   endtask

   initial begin
      int n;
      bit fell;
      longint frozen;

      tx_s[0] = 9'h1FF;
      tx_s[1] = 9'h0A5;
      model_reset();
      do_reset();

      // All-zero data must never lock
      for (int i = 0; i < 5000; i++) sym(1, 1, 90, 0, 0, 0);
      sym(0, 0, 90, 0, 0, 0); sym(0, 0, 90, 0, 0, 0);
      chk("zero_lock", lock, 0);
      chk("zero_bits", bit_count, 0);
      chk("zero_errs", err_count, 0);

      // Noise-free acquisition and 1000-symbol count
      do_reset();
      wait_lock(200, n);
      chk("acq_lock", lock, 1);
      chk("acq_latency_ok", (n >= 70 && n <= 80), 1);
      sym(0, 0, 90, 0, 0, 0); sym(0, 0, 90, 0, 0, 0);
      sym(0, 0, 90, 0, 0, 1);
      for (int i = 0; i < 1000; i++) sym(1, 0, 90, 0, 0, 0);
      sym(0, 0, 90, 0, 0, 0); sym(0, 0, 90, 0, 0, 0);
      chk("clean_bits", bit_count, 2000);
      chk("clean_errs", err_count, 0);

      // Three isolated I inversions
      sym(0, 0, 90, 0, 0, 1);
      pulses_i = 0;
      for (int i = 0; i < 300; i++) sym(1, 0, 90, (i == 50 || i == 120 || i == 200), 0, 0);
      sym(0, 0, 90, 0, 0, 0); sym(0, 0, 90, 0, 0, 0);
      chk("inj_pulses", pulses_i, 3);
      chk("inj_errs", err_count, 3);
      chk("inj_bits", bit_count, 600);
      chk("inj_lock", lock, 1);

      // clr coincides with an error reaching the counters
      sym(1, 0, 90, 1, 0, 0);
      sym(1, 0, 90, 0, 0, 1);
      sym(0, 0, 90, 0, 0, 0);
      chk("clr_bits", bit_count, 0);
      chk("clr_errs", err_count, 0);
      chk("clr_pulse", err_I, 1);

      // Random data: lock must drop at a window boundary and counts must freeze
      fell = 1'b0; frozen = 0;
      for (int i = 0; i < 2 * WIN_LEN; i++) begin
         sym(1, 2, 90, 0, 0, 0);
         if (!fell && !lock) begin
            fell = 1'b1;
            frozen = longint'(bit_count);
         end
      end
      chk("loss_lock", lock, 0);
      chk("loss_frozen", bit_count, frozen);
      wait_lock(300, n);
      chk("relock_after_loss", lock, 1);

      // Randomized amplitudes, gaps, clears and sparse errors on both branches
      for (int i = 0; i < 3000; i++)
         sym(($urandom_range(0, 9) != 0), 0, 0, ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));

      // Saturation: +2 from max-1 clamps to max
      sym(0, 0, 90, 0, 0, 1);
      for (int i = 0; i < 2200; i++) sym(1, 0, 90, 0, 0, 0);
      sym(0, 0, 90, 0, 0, 0); sym(0, 0, 90, 0, 0, 0);
      chk("sat_bits", bit_count, CMAX);
      chk("sat_lock", lock, 1);

      // Reset while locked, then re-acquire from scratch
      do_reset();
      wait_lock(200, n);
      chk("rst_relock", lock, 1);
      chk("rst_relock_latency_ok", (n >= 70 && n <= 80), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_prbs_ber_checker.md
Name: rx_prbs_ber_checker

Overview:
- Receiver-side bit-error-rate checker at the output of the complex noisy channel model.
- Slices each complex sample (In_I, In_Q; Q7, S(16,7)) into a hard QPSK decision per branch.
- Self-synchronises a local PRBS9 on each branch to the transmitted sequence, then counts compared bits and bit errors while locked.
- Used in closed-loop simulation and FPGA bring-up: PRBS QPSK source -> channel -> this block.

Parameters:
- DWIDTH, 16, width of In_I/In_Q.
- LOCK_CNT, 64, consecutive correct predictions needed to declare branch lock.
- WIN_LEN, 1024, symbols per loss-of-lock observation window.
- LOSS_THR, 64, errors within one window that force a return to search.
- CNT_W, 32, width of bit_count/err_count.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- clr, in, 1, synchronous clear of bit_count/err_count only; lock state is not affected.
- in_valid, in, 1, In_I/In_Q valid this cycle.
- In_I, in, DWIDTH signed, received in-phase sample.
- In_Q, in, DWIDTH signed, received quadrature sample.
- lock, out, 1, both branches LOCKED.
- bit_count, out, CNT_W, bits compared while lock=1 (saturating).
- err_count, out, CNT_W, bit errors while lock=1 (saturating).
- err_I, out, 1, one-cycle pulse: I-branch mismatch on a locked symbol.
- err_Q, out, 1, one-cycle pulse: Q-branch mismatch on a locked symbol.

Behaviour:
- Slicer (stage 1, registered):
  - d_I = In_I[DWIDTH-1] (bit 1 if negative); same rule for d_Q.
  - Zero slices to 0.
  - d_valid = in_valid, delayed one cycle.
- Branch checker (stage 2, one instance per branch):
  - 9-bit shift register sr; PRBS9 x^9+x^5+1; prediction p = sr[8]^sr[4].
  - Updates only when d_valid=1.
  - SEARCH state:
    - sr <= {sr[7:0], d}.
    - If p==d and sr!=0: match_cnt++; otherwise match_cnt <= 0.
    - Transition to LOCKED on the symbol where match_cnt reaches LOCK_CNT.
    - The sr!=0 guard prevents lock on an all-zero input stream.
  - LOCKED state:
    - sr <= {sr[7:0], p} (free-running, decisions no longer fed back).
    - mismatch = (p != d).
    - win_cnt counts symbols and err_win counts mismatches.
    - When win_cnt wraps at WIN_LEN: if err_win >= LOSS_THR, go to SEARCH and clear match_cnt; otherwise stay LOCKED. err_win clears at every wrap.
- Aggregation (registered with stage 2):
  - lock = lock_I & lock_Q.
  - On d_valid with lock=1: bit_count += 2, err_count += mismatch_I + mismatch_Q.
  - err_I/err_Q pulse only when lock=1.
- Latency: sample at edge k -> err_I/err_Q/count update visible after edge k+2.
- Saturation: bit_count and err_count hold at all-ones and never wrap. A +2 increment from max-1 clamps to max.
- clr:
  - Zeroes both counts in that cycle; clr has priority over a simultaneous increment.
  - Does not touch sr, state, or windows.
- Lock drop: counting stops on the cycle lock falls; counts hold their values.
- in_valid=0 gaps: all state frozen; pulses low.
- Reset:
  - All outputs 0, both branches in SEARCH, sr=0, match_cnt/win_cnt/err_win=0, pipeline valid cleared.
  - Reset mid-lock behaves the same; the block re-searches from scratch.

Optional Feature:
- Macro: RX_ERR_INJECT_EN.
- Defined:
  - Adds input err_inject (1 bit).
  - When in_valid & err_inject, the stage-1 I decision is inverted for that symbol.
  - Used to verify the error path deterministically.
- Undefined: port absent; decisions unmodified.

Decomposition:
- Package rx_ber_pkg:
  - PRBS9 order and tap positions (9, 5).
  - SEARCH/LOCKED state encoding.
  - Saturating-add helper function.
- One sub-module, prbs9_sync_checker: input d, d_valid; outputs locked and mismatch. Instantiated twice.
- Top level holds the slicer, aggregation, counters and clr.

Test Plan:
- Noise-free PRBS9 on both branches (I seed 9'h1FF, Q seed 9'h0A5), amplitude ±90:
  - lock rises after about 9+64 symbols plus 2 cycles.
  - After 1000 further symbols: bit_count=2000, err_count=0.
- All-zero input (In_I=In_Q=+90 constant) for 5000 symbols -> lock stays 0, counts stay 0.
- Locked stream with I inverted on 3 isolated symbols (RX_ERR_INJECT_EN) -> exactly 3 err_I pulses, err_count=3, lock held.
- Locked, then random data for 2×WIN_LEN symbols:
  - lock drops at the first window boundary with ≥64 errors.
  - Counts freeze; PRBS restored -> relock.
- Preload bit_count to 2^32-2 (force) and run locked -> saturates at 2^32-1.
- clr asserted in the same cycle as an error -> both counts read 0 next cycle.
- rst pulsed mid-lock -> all outputs 0 next edge; relock after about 73 symbols.
